// File: rtl/wait_cmd_ctrl_tb_pkg.sv
// rtl/wait_cmd_ctrl_tb_pkg.sv - shared types and constants for the wait-command sequencer
package wait_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_WTR  = 2'd0,
    CMD_WTF  = 2'd1,
    CMD_DLY  = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_type_t;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_TIMEOUT = 2'd1,
    RSP_BAD_CMD = 2'd2
  } rsp_status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DLY  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Cycles from the checker's internal timeout to its done pulse being sampled here.
  localparam int unsigned TIMEOUT_LAT = 2;

endpackage

// File: rtl/wait_cmd_ctrl_tb_if.sv
// rtl/wait_cmd_ctrl_tb_if.sv - command, checker and response signals of the wait-command sequencer
interface wait_cmd_ctrl_tb_if #(
  parameter int CNT_W = 32
);

  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic [1:0]       i_cmd_type;
  logic [31:0]      i_cmd_sel;
  logic [CNT_W-1:0] i_cmd_timeout;

  logic             o_en_wait_event;
  logic [31:0]      o_wait_en;
  logic             o_sel_wtr_wtf;
  logic [CNT_W-1:0] o_max_timeout;
  logic             i_wait_done;

  logic             o_rsp_valid;
  logic             i_rsp_ready;
  logic [1:0]       o_rsp_status;
  logic [CNT_W-1:0] o_rsp_cycles;
  logic             o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_type, i_cmd_sel, i_cmd_timeout, i_wait_done, i_rsp_ready,
    output o_cmd_ready, o_en_wait_event, o_wait_en, o_sel_wtr_wtf, o_max_timeout,
           o_rsp_valid, o_rsp_status, o_rsp_cycles, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_type, i_cmd_sel, i_cmd_timeout, i_wait_done, i_rsp_ready,
    input  o_cmd_ready, o_en_wait_event, o_wait_en, o_sel_wtr_wtf, o_max_timeout,
           o_rsp_valid, o_rsp_status, o_rsp_cycles, o_busy
  );

endinterface

// File: rtl/wait_cmd_ctrl_tb.sv
// rtl/wait_cmd_ctrl_tb.sv - sequences one WTR/WTF/DLY wait command against the wait-event checker
module wait_cmd_ctrl_tb
  import wait_cmd_pkg::*;
#(
  parameter int WAIT_SIZE = 5,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  wait_cmd_ctrl_tb_if.slave  bus
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tmo;

  cmd_type_t        cmd_type;
  logic             cmd_bad;
  logic [CNT_W-1:0] cnt_sat_inc;
  logic [CNT_W:0]   k_ext;
  logic [CNT_W:0]   tmo_lim;
  logic             wait_timed_out;

  assign cmd_type = cmd_type_t'(bus.i_cmd_type);
  // The line select only matters for the edge waits; DLY ignores it.
  assign cmd_bad  = (cmd_type == CMD_RSVD) ||
                    ((cmd_type != CMD_DLY) && (bus.i_cmd_sel >= 32'(WAIT_SIZE)));

  assign cnt_sat_inc = (&cnt) ? cnt : cnt + 1'b1;

  // Compare one bit wider so timeout+latency cannot wrap near all-ones.
  assign k_ext          = {1'b0, cnt} + 1'b1;
  assign tmo_lim        = {1'b0, tmo} + (CNT_W+1)'(TIMEOUT_LAT);
  assign wait_timed_out = (tmo != '0) && (k_ext >= tmo_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      tmo                 <= '0;
      bus.o_cmd_ready     <= 1'b1;
      bus.o_en_wait_event <= 1'b0;
      bus.o_wait_en       <= '0;
      bus.o_sel_wtr_wtf   <= 1'b0;
      bus.o_max_timeout   <= '0;
      bus.o_rsp_valid     <= 1'b0;
      bus.o_rsp_status    <= '0;
      bus.o_rsp_cycles    <= '0;
      bus.o_busy          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_cmd_valid) begin
            cnt             <= '0;
            tmo             <= bus.i_cmd_timeout;
            bus.o_cmd_ready <= 1'b0;
            bus.o_busy      <= 1'b1;
            if (cmd_bad) begin
              state            <= S_RESP;
              bus.o_rsp_valid  <= 1'b1;
              bus.o_rsp_status <= RSP_BAD_CMD;
              bus.o_rsp_cycles <= '0;
            end else if (cmd_type == CMD_DLY) begin
              if (bus.i_cmd_timeout == '0) begin
                state            <= S_RESP;
                bus.o_rsp_valid  <= 1'b1;
                bus.o_rsp_status <= RSP_OK;
                bus.o_rsp_cycles <= '0;
              end else begin
                state <= S_DLY;
              end
            end else begin
              state               <= S_WAIT;
              bus.o_en_wait_event <= 1'b1;
              bus.o_wait_en       <= bus.i_cmd_sel;
              bus.o_sel_wtr_wtf   <= bus.i_cmd_type[0];
              bus.o_max_timeout   <= bus.i_cmd_timeout;
            end
          end
        end

        S_WAIT: begin
          if (bus.i_wait_done) begin
            state               <= S_RESP;
            bus.o_en_wait_event <= 1'b0;
            bus.o_rsp_valid     <= 1'b1;
            bus.o_rsp_cycles    <= cnt_sat_inc;
            bus.o_rsp_status    <= wait_timed_out ? RSP_TIMEOUT : RSP_OK;
          end else begin
            cnt <= cnt_sat_inc;
          end
        end

        S_DLY: begin
          cnt <= cnt + 1'b1;
          if ((cnt + 1'b1) == tmo) begin
            state            <= S_RESP;
            bus.o_rsp_valid  <= 1'b1;
            bus.o_rsp_status <= RSP_OK;
            bus.o_rsp_cycles <= tmo;
          end
        end

        S_RESP: begin
          // Enable stays low here and in IDLE, giving the checker time to clear.
          if (bus.i_rsp_ready) begin
            state           <= S_IDLE;
            bus.o_rsp_valid <= 1'b0;
            bus.o_cmd_ready <= 1'b1;
            bus.o_busy      <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wait_cmd_ctrl_tb.sv
// tb/tb_wait_cmd_ctrl_tb.sv - directed bench for the wait-command sequencer with a small checker model
module tb_wait_cmd_ctrl_tb;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  wait_cmd_ctrl_tb_if #(.CNT_W(32)) bus ();

  wait_cmd_ctrl_tb #(.WAIT_SIZE(5), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker stand-in: done one cycle after an edge is seen, or one cycle after T enabled cycles.
  logic [4:0]  line;
  logic [4:0]  line_d;
  logic [31:0] tcnt;
  logic        chk_fin;
  logic        en_d;
  logic        edge_hit;
  int          done_pulses;
  int          en_rises;

  always_comb begin
    edge_hit = 1'b0;
    if (bus.o_wait_en < 32'd5) begin
      if (bus.o_sel_wtr_wtf)
        edge_hit = !line[bus.o_wait_en[2:0]] && line_d[bus.o_wait_en[2:0]];
      else
        edge_hit = line[bus.o_wait_en[2:0]] && !line_d[bus.o_wait_en[2:0]];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      line_d          <= '0;
      tcnt            <= '0;
      chk_fin         <= 1'b0;
      en_d            <= 1'b0;
      bus.i_wait_done <= 1'b0;
    end else begin
      line_d          <= line;
      en_d            <= bus.o_en_wait_event;
      bus.i_wait_done <= 1'b0;
      if (bus.i_wait_done) done_pulses <= done_pulses + 1;
      if (bus.o_en_wait_event && !en_d) en_rises <= en_rises + 1;
      if (!bus.o_en_wait_event) begin
        tcnt    <= '0;
        chk_fin <= 1'b0;
      end else if (!chk_fin) begin
        tcnt <= tcnt + 1;
        if (edge_hit || (bus.o_max_timeout != 0 && tcnt == bus.o_max_timeout)) begin
          bus.i_wait_done <= 1'b1;
          chk_fin         <= 1'b1;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [31:0] s, input logic [31:0] to);
    bus.i_cmd_type    = t;
    bus.i_cmd_sel     = s;
    bus.i_cmd_timeout = to;
    bus.i_cmd_valid   = 1'b1;
    check_eq("cmd_ready_before_accept", bus.o_cmd_ready, 1);
    tick();
    bus.i_cmd_valid   = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.o_rsp_valid && n < 1000) begin
      tick();
      n++;
    end
    check_eq("rsp_valid_seen", bus.o_rsp_valid, 1);
  endtask

  task automatic take_rsp();
    bus.i_rsp_ready = 1'b1;
    tick();
    bus.i_rsp_ready = 1'b0;
    check_eq("rsp_valid_after_take", bus.o_rsp_valid, 0);
    check_eq("cmd_ready_after_take", bus.o_cmd_ready, 1);
    check_eq("busy_after_take", bus.o_busy, 0);
  endtask

  initial begin
    int n;
    int rises0;
    n_tests          = 0;
    n_fail           = 0;
    done_pulses      = 0;
    en_rises         = 0;
    line             = 5'b00001;
    rst              = 1'b1;
    bus.i_cmd_valid  = 1'b0;
    bus.i_cmd_type   = '0;
    bus.i_cmd_sel    = '0;
    bus.i_cmd_timeout= '0;
    bus.i_rsp_ready  = 1'b0;

    #3;
    check_eq("rst_cmd_ready", bus.o_cmd_ready, 1);
    check_eq("rst_en", bus.o_en_wait_event, 0);
    check_eq("rst_rsp_valid", bus.o_rsp_valid, 0);
    check_eq("rst_busy", bus.o_busy, 0);
    check_eq("rst_status", bus.o_rsp_status, 0);
    check_eq("rst_cycles", bus.o_rsp_cycles, 0);
    check_eq("rst_wait_en", bus.o_wait_en, 0);
    check_eq("rst_max_timeout", bus.o_max_timeout, 0);
    check_eq("rst_sel", bus.o_sel_wtr_wtf, 0);
    #9 rst = 1'b0;
    tick();

    // WTR on line 2, rising edge lands 10 enabled cycles in
    send_cmd(2'd0, 32'd2, 32'd100);
    check_eq("wtr_en", bus.o_en_wait_event, 1);
    check_eq("wtr_wait_en", bus.o_wait_en, 2);
    check_eq("wtr_sel", bus.o_sel_wtr_wtf, 0);
    check_eq("wtr_max_to", bus.o_max_timeout, 100);
    check_eq("wtr_busy", bus.o_busy, 1);
    for (int i = 0; i < 9; i++) tick();
    line[2] = 1'b1;
    wait_rsp(n);
    check_eq("wtr_latency", n + 9, 11);
    check_eq("wtr_status", bus.o_rsp_status, 0);
    check_eq("wtr_cycles", bus.o_rsp_cycles, 11);
    check_eq("wtr_en_low", bus.o_en_wait_event, 0);
    check_eq("wtr_done_pulses", done_pulses, 1);
    take_rsp();

    // WTF on line 0 held high -> checker times out
    send_cmd(2'd1, 32'd0, 32'd20);
    check_eq("wtf_sel", bus.o_sel_wtr_wtf, 1);
    wait_rsp(n);
    check_eq("wtf_latency", n, 22);
    check_eq("wtf_status", bus.o_rsp_status, 1);
    check_eq("wtf_cycles", bus.o_rsp_cycles, 22);
    check_eq("wtf_en_low_resp", bus.o_en_wait_event, 0);
    take_rsp();
    check_eq("wtf_en_low_idle", bus.o_en_wait_event, 0);
    check_eq("wtf_done_pulses", done_pulses, 2);

    // Bad commands answer one edge after accept without enabling the checker
    rises0 = en_rises;
    send_cmd(2'd3, 32'd0, 32'd5);
    check_eq("bad_type_valid", bus.o_rsp_valid, 1);
    check_eq("bad_type_status", bus.o_rsp_status, 2);
    check_eq("bad_type_cycles", bus.o_rsp_cycles, 0);
    check_eq("bad_type_en", bus.o_en_wait_event, 0);
    take_rsp();
    send_cmd(2'd0, 32'd5, 32'd10);
    check_eq("bad_sel_valid", bus.o_rsp_valid, 1);
    check_eq("bad_sel_status", bus.o_rsp_status, 2);
    check_eq("bad_sel_cycles", bus.o_rsp_cycles, 0);
    take_rsp();
    send_cmd(2'd1, 32'hFFFF_FFFF, 32'd10);
    check_eq("bad_neg_status", bus.o_rsp_status, 2);
    take_rsp();
    check_eq("bad_no_en_rise", en_rises, rises0);

    // Fixed delays
    send_cmd(2'd2, 32'd9, 32'd7);
    wait_rsp(n);
    check_eq("dly7_latency", n, 7);
    check_eq("dly7_status", bus.o_rsp_status, 0);
    check_eq("dly7_cycles", bus.o_rsp_cycles, 7);
    take_rsp();
    send_cmd(2'd2, 32'd0, 32'd0);
    check_eq("dly0_valid", bus.o_rsp_valid, 1);
    check_eq("dly0_status", bus.o_rsp_status, 0);
    check_eq("dly0_cycles", bus.o_rsp_cycles, 0);
    take_rsp();
    check_eq("dly_no_en_rise", en_rises, rises0);

    // Back-pressured response with a competing command waiting
    send_cmd(2'd2, 32'd0, 32'd3);
    wait_rsp(n);
    check_eq("hold_latency", n, 3);
    bus.i_cmd_type    = 2'd0;
    bus.i_cmd_sel     = 32'd1;
    bus.i_cmd_timeout = 32'd5;
    bus.i_cmd_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_cmd_ready", bus.o_cmd_ready, 0);
      check_eq("hold_rsp_valid", bus.o_rsp_valid, 1);
      check_eq("hold_status", bus.o_rsp_status, 0);
      check_eq("hold_cycles", bus.o_rsp_cycles, 3);
    end
    bus.i_cmd_valid = 1'b0;
    take_rsp();
    check_eq("hold_no_accept", en_rises, rises0);

    // Asynchronous reset mid-wait, then a normal WTR
    send_cmd(2'd0, 32'd3, 32'd0);
    tick();
    tick();
    check_eq("rstw_en_before", bus.o_en_wait_event, 1);
    #3 rst = 1'b1;
    #1;
    check_eq("rstw_en", bus.o_en_wait_event, 0);
    check_eq("rstw_rsp_valid", bus.o_rsp_valid, 0);
    check_eq("rstw_busy", bus.o_busy, 0);
    check_eq("rstw_cmd_ready", bus.o_cmd_ready, 1);
    #3 rst = 1'b0;
    tick();
    check_eq("rstw_ready_after", bus.o_cmd_ready, 1);
    send_cmd(2'd0, 32'd3, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    line[3] = 1'b1;
    wait_rsp(n);
    check_eq("post_rst_latency", n + 4, 6);
    check_eq("post_rst_status", bus.o_rsp_status, 0);
    check_eq("post_rst_cycles", bus.o_rsp_cycles, 6);
    take_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
